// File: rtl/tree_lru_victim.sv
// Per-set tree-PLRU table with a registered victim walk and a one-set-per-cycle flush sweeper.
// Optional macro TREE_LRU_VICTIM_LOCK_EN makes the walk steer around locked ways.
module tree_lru_victim #(
  parameter int WAYS     = 4,
  parameter int NUM_SETS = 64,
  parameter int SET_W    = $clog2(NUM_SETS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  output logic                     busy_o,
  input  logic                     lookup_valid_i,
  input  logic [SET_W-1:0]         lookup_set_i,
  output logic                     victim_valid_o,
  output logic [WAYS-1:0]          victim_oh_o,
  output logic [$clog2(WAYS)-1:0]  victim_idx_o,
  input  logic                     upd_valid_i,
  input  logic [SET_W-1:0]         upd_set_i,
  input  logic [WAYS-1:0]          upd_way_oh_i,
  input  logic [WAYS-1:0]          lock_mask_i
);

  localparam int LEVELS = $clog2(WAYS);

  typedef enum logic {IDLE, SWEEP} state_t;

  // Node n of the heap lives at bit n; bit 0 does not exist.
  logic [WAYS-1:1]             r_tree [NUM_SETS];
  state_t                      r_state;
  logic [SET_W-1:0]            r_cnt;
  logic                        r_busy;
  logic                        r_valid;
  logic [WAYS-1:0]             r_oh;
  logic [LEVELS-1:0]           r_idx;

  logic                        w_sweep_we;
  logic                        w_upd_we;
  logic [LEVELS-1:0][WAYS-1:0] w_idx_sel;
  logic [LEVELS-1:0]           w_upd_idx;
  logic [LEVELS:0]             w_upd_leaf;
  logic [WAYS-1:1]             w_upd_old;
  logic [WAYS-1:1]             w_upd_bits;
  logic [WAYS-1:1]             w_lk_bits;
  logic [LEVELS:0]             w_node;
  logic                        w_dir;
  logic                        w_all_locked;
  logic [LEVELS-1:0]           w_vic_idx;
  logic [WAYS-1:0]             w_vic_oh;

  assign w_sweep_we = (r_state == SWEEP);
  assign w_upd_we   = upd_valid_i && (|upd_way_oh_i) && !w_sweep_we;

  // One-hot to binary: bit gb of the index is the OR of the ways whose number has bit gb set.
  for (genvar gb = 0; gb < LEVELS; gb++) begin : g_idx_bit
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_idx_way
      if (((gi >> gb) % 2) == 1) begin : g_on
        assign w_idx_sel[gb][gi] = upd_way_oh_i[gi];
      end else begin : g_off
        assign w_idx_sel[gb][gi] = 1'b0;
      end
    end
    assign w_upd_idx[gb] = |w_idx_sel[gb];
  end

  assign w_upd_leaf = {1'b1, w_upd_idx};
  assign w_upd_old  = r_tree[upd_set_i];

  // A node is on the touched path when the leaf's ancestor at that depth is this node;
  // the next index bit (0 = left) decides whether the node points right (1) or left (0).
  for (genvar gi = 1; gi < WAYS; gi++) begin : g_upd_node
    localparam int              DEP  = $clog2(gi + 1) - 1;
    localparam logic [LEVELS:0] NODE = (LEVELS + 1)'(gi);
    assign w_upd_bits[gi] = ((w_upd_leaf >> (LEVELS - DEP)) == NODE)
                            ? ~w_upd_idx[LEVELS-1-DEP] : w_upd_old[gi];
  end

  // Lookups see the bits as they will be after this cycle's write.
  always_comb begin
    w_lk_bits = r_tree[lookup_set_i];
    if (w_sweep_we && (r_cnt == lookup_set_i)) begin
      w_lk_bits = '0;
    end else if (w_upd_we && (upd_set_i == lookup_set_i)) begin
      w_lk_bits = w_upd_bits;
    end
  end

`ifdef TREE_LRU_VICTIM_LOCK_EN
  logic [2*WAYS-1:1] w_sub_lock;

  // Subtree of node gi covers a contiguous run of ways.
  for (genvar gi = 1; gi < 2*WAYS; gi++) begin : g_sub_lock
    localparam int DEP  = $clog2(gi + 1) - 1;
    localparam int SPAN = 1 << (LEVELS - DEP);
    localparam int LO   = gi * SPAN - WAYS;
    assign w_sub_lock[gi] = &lock_mask_i[LO +: SPAN];
  end
  assign w_all_locked = w_sub_lock[1];
`else
  logic w_unused_lock;
  assign w_unused_lock = ^lock_mask_i;
  assign w_all_locked  = 1'b0;
`endif

  always_comb begin
    w_node = (LEVELS + 1)'(1);
    w_dir  = 1'b0;
    for (int d = 0; d < LEVELS; d++) begin
      w_dir = w_lk_bits[w_node[LEVELS-1:0]];
`ifdef TREE_LRU_VICTIM_LOCK_EN
      if (w_sub_lock[{w_node[LEVELS-1:0], w_dir}]) begin
        w_dir = ~w_dir;
      end
`endif
      w_node = {w_node[LEVELS-1:0], w_dir};
    end
  end

  // After LEVELS steps the walk sits on leaf WAYS+way, so the low bits are the way.
  assign w_vic_idx = (w_node[LEVELS] && !w_all_locked) ? w_node[LEVELS-1:0] : '0;
  assign w_vic_oh  = w_all_locked ? '0 : (WAYS'(1) << w_vic_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_tree[s] <= '0;
      end
    end else if (w_sweep_we) begin
      r_tree[r_cnt] <= '0;
    end else if (w_upd_we) begin
      r_tree[upd_set_i] <= w_upd_bits;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (flush_i) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (flush_i) begin
            r_cnt <= '0;
          end else if (r_cnt == SET_W'(NUM_SETS - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_oh    <= WAYS'(1);
      r_idx   <= '0;
    end else begin
      r_valid <= lookup_valid_i;
      if (lookup_valid_i) begin
        r_oh  <= w_vic_oh;
        r_idx <= w_vic_idx;
      end
    end
  end

  assign busy_o         = r_busy;
  assign victim_valid_o = r_valid;
  assign victim_oh_o    = r_oh;
  assign victim_idx_o   = r_idx;

endmodule
